mem_access_ctrl: RTL and testbench

Sequencer between the Memory stage and a word-wide synchronous data RAM. The RAM has 1-cycle read latency, whole-word write and no byte enables.
- Translates RV32I load/store requests (funct3 size/sign) into RAM operations.
- Sub-word stores use read-modify-write; loads wait one cycle for RAM data.
- Drives a stall to freeze Fetch/Decode/Execute/Memory while an access is in progress.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_lane_unit.sv | 58 +++++
 rtl/mem_access_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared FSM state and funct3 constants for mem_access_ctrl
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_DATA = 2'd1,
        RMW_WRITE = 2'd2
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_lane_unit.sv
// rtl/mem_lane_unit.sv - load lane select/extend, store lane merge, misalign/illegal detect
module mem_lane_unit
    import mem_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic               we,
    input  logic [2:0]         funct3,
    input  logic [1:0]         addr_lo,
    input  logic [D_WIDTH-1:0] ram_rdata,
    input  logic [D_WIDTH-1:0] wdata,
    output logic [D_WIDTH-1:0] load_data,
    output logic [D_WIDTH-1:0] merged_wdata,
    output logic               err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        illegal;
    logic        misaligned;
    logic        unused_wdata_hi;

    assign unused_wdata_hi = ^wdata[D_WIDTH-1:16];

    always_comb begin
        byte_sel = ram_rdata[{addr_lo, 3'b000} +: 8];
        half_sel = ram_rdata[{addr_lo[1], 4'b0000} +: 16];

        if (we) begin
            illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        end else begin
            illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                        funct3 == F3_BU || funct3 == F3_HU);
        end

        misaligned = ((funct3 == F3_H || funct3 == F3_HU) && addr_lo[0]) ||
                     ((funct3 == F3_W) && (addr_lo != 2'b00));
        err = illegal || misaligned;

        case (funct3)
            F3_B:    load_data = {{(D_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{(D_WIDTH-16){half_sel[15]}}, half_sel};
            F3_W:    load_data = ram_rdata;
            F3_BU:   load_data = {{(D_WIDTH-8){1'b0}}, byte_sel};
            F3_HU:   load_data = {{(D_WIDTH-16){1'b0}}, half_sel};
            default: load_data = '0;
        endcase

        // Only SB/SH reach the merge path, so anything not a halfword is a byte
        merged_wdata = ram_rdata;
        if (funct3 == F3_H) begin
            merged_wdata[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
        end else begin
            merged_wdata[{addr_lo, 3'b000} +: 8] = wdata[7:0];
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store sequencer for a word-wide 1-cycle-latency RAM
// Optional statistics counters enabled by MEM_ACCESS_CTRL_STATS_EN.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int D_WIDTH   = 32,
    parameter int A_WIDTH   = 17,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [D_WIDTH-1:0]   req_addr,
    input  logic [D_WIDTH-1:0]   req_wdata,
    output logic                 stall_o,
    output logic [D_WIDTH-1:0]   rdata_o,
    output logic                 rdata_valid_o,
    output logic                 err_o,
    output logic [A_WIDTH-3:0]   ram_addr,
    output logic                 ram_we,
    output logic [D_WIDTH-1:0]   ram_wdata,
    input  logic [D_WIDTH-1:0]   ram_rdata,
    output logic [CNT_WIDTH-1:0] load_cnt,
    output logic [CNT_WIDTH-1:0] store_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    mem_state_t state_q, state_d;

    logic [D_WIDTH-1:0] load_data;
    logic [D_WIDTH-1:0] merged_wdata;
    logic               lane_err;
    logic               unused_addr_bits;

    assign ram_addr         = req_addr[A_WIDTH-1:2];
    assign unused_addr_bits = ^{req_addr[D_WIDTH-1:A_WIDTH]};

    mem_lane_unit #(.D_WIDTH(D_WIDTH)) u_lane (
        .we           (req_we),
        .funct3       (req_funct3),
        .addr_lo      (req_addr[1:0]),
        .ram_rdata    (ram_rdata),
        .wdata        (req_wdata),
        .load_data    (load_data),
        .merged_wdata (merged_wdata),
        .err          (lane_err)
    );

    always_comb begin
        state_d       = state_q;
        stall_o       = 1'b0;
        rdata_o       = '0;
        rdata_valid_o = 1'b0;
        err_o         = 1'b0;
        ram_we        = 1'b0;
        ram_wdata     = req_wdata;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (lane_err) begin
                        err_o         = 1'b1;
                        rdata_valid_o = !req_we;
                    end else if (req_we && req_funct3 == F3_W) begin
                        ram_we = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                        state_d = req_we ? RMW_WRITE : LOAD_DATA;
                    end
                end
            end
            LOAD_DATA: begin
                rdata_valid_o = 1'b1;
                rdata_o       = load_data;
                state_d       = IDLE;
            end
            RMW_WRITE: begin
                ram_we    = 1'b1;
                ram_wdata = merged_wdata;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset squashes any in-flight write or load result immediately
        if (rst) begin
            state_d       = IDLE;
            stall_o       = 1'b0;
            rdata_o       = '0;
            rdata_valid_o = 1'b0;
            err_o         = 1'b0;
            ram_we        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MEM_ACCESS_CTRL_STATS_EN
    logic [CNT_WIDTH-1:0] load_cnt_q, load_cnt_d;
    logic [CNT_WIDTH-1:0] store_cnt_q, store_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (rdata_valid_o && !err_o && load_cnt_q != '1) begin
            load_cnt_d = load_cnt_q + 1'b1;
        end
        if (ram_we && store_cnt_q != '1) begin
            store_cnt_d = store_cnt_q + 1'b1;
        end
        if (stall_o && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign load_cnt  = '0;
    assign store_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with a behavioural RAM
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        err_o;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] load_cnt;
    logic [31:0] store_cnt;
    logic [31:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [14:0] waddr;
        logic [31:0] wdata;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    logic [31:0] mem [0:32767];

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .err_o         (err_o),
        .ram_addr      (ram_addr),
        .ram_we        (ram_we),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .load_cnt      (load_cnt),
        .store_cnt     (store_cnt),
        .stall_cnt     (stall_cnt)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (rdata_valid_o || ram_we || err_o)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: we=%b rv=%b err=%b, none expected",
                         ram_we, rdata_valid_o, err_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ram_we", {31'd0, ram_we}, {31'd0, e.we});
                chk("rdata_valid", {31'd0, rdata_valid_o}, {31'd0, e.rvalid});
                chk("err", {31'd0, err_o}, {31'd0, e.err});
                if (e.we) begin
                    chk("ram_addr", {17'd0, ram_addr}, {17'd0, e.waddr});
                    chk("ram_wdata", ram_wdata, e.wdata);
                end
                if (e.rvalid) chk("rdata", rdata_o, e.rdata);
            end
        end
    end

    function automatic exp_t mk(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                input logic rv, input logic [31:0] rd, input logic er);
        exp_t e;
        e.we = we; e.waddr = a[16:2]; e.wdata = wd; e.rvalid = rv; e.rdata = rd; e.err = er;
        return e;
    endfunction

    // Called just after a posedge; returns just after the posedge ending the access
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int exp_stalls, input string name);
        int stalls;
        stalls     = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(negedge clk);
        while (stall_o && stalls < 8) begin
            stalls++;
            @(negedge clk);
        end
        chk({name, "_stalls"}, stalls, exp_stalls);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 32'd0;
        mem[32'h100 >> 2] = 32'h8899AABB;
        mem[32'h300 >> 2] = 32'hAABBCCDD;
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_rvalid", {31'd0, rdata_valid_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;

        exp_q.push_back(mk(0, 0, 0, 1, 32'hFFFFFFAA, 0));
        issue(0, 3'b000, 32'h101, 0, 1, "lb");
        exp_q.push_back(mk(0, 0, 0, 1, 32'h00000088, 0));
        issue(0, 3'b100, 32'h103, 0, 1, "lbu");
        exp_q.push_back(mk(0, 0, 0, 1, 32'hFFFF8899, 0));
        issue(0, 3'b001, 32'h102, 0, 1, "lh");
        exp_q.push_back(mk(0, 0, 0, 1, 32'h0000AABB, 0));
        issue(0, 3'b101, 32'h100, 0, 1, "lhu");
        exp_q.push_back(mk(1, 32'h200, 32'h12345678, 0, 0, 0));
        issue(1, 3'b010, 32'h200, 32'h12345678, 0, "sw");
        exp_q.push_back(mk(0, 0, 0, 1, 32'h12345678, 0));
        issue(0, 3'b010, 32'h200, 0, 1, "lw");
        exp_q.push_back(mk(1, 32'h302, 32'h1122CCDD, 0, 0, 0));
        issue(1, 3'b001, 32'h302, 32'hFFFF1122, 1, "sh");
        exp_q.push_back(mk(1, 32'h300, 32'h1122CCEE, 0, 0, 0));
        issue(1, 3'b000, 32'h300, 32'h123456EE, 1, "sb");
        exp_q.push_back(mk(0, 0, 0, 1, 32'h0, 1));
        issue(0, 3'b010, 32'h205, 0, 0, "lw_misaligned");
        chk("ram_unchanged_200", mem[32'h200 >> 2], 32'h12345678);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1));
        issue(1, 3'b011, 32'h200, 32'hDEADBEEF, 0, "store_f3_011");
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1));
        issue(1, 3'b001, 32'h301, 32'hDEADBEEF, 0, "sh_misaligned");
        chk("ram_unchanged_200b", mem[32'h200 >> 2], 32'h12345678);
        chk("ram_unchanged_300", mem[32'h300 >> 2], 32'h1122CCEE);

        // SB aborted by reset during RMW_WRITE
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h300; req_wdata = 32'h55;
        @(negedge clk);
        chk("rmw_stall", {31'd0, stall_o}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rmw_rst_ram_we", {31'd0, ram_we}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("rmw_rst_idle_we", {31'd0, ram_we}, 32'd0);
        chk("rmw_rst_idle_stall", {31'd0, stall_o}, 32'd0);
        chk("rmw_rst_word", mem[32'h300 >> 2], 32'h1122CCEE);
        @(posedge clk); #1;

        // Load discarded by reset during LOAD_DATA
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200;
        @(negedge clk);
        chk("ld_stall", {31'd0, stall_o}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("ld_rst_rvalid", {31'd0, rdata_valid_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("ld_rst_idle_rvalid", {31'd0, rdata_valid_o}, 32'd0);
        @(posedge clk); #1;

        // Counter sequence starts from a fresh reset
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 1, 32'h12345678, 0));
        issue(0, 3'b010, 32'h200, 0, 1, "cnt_lw");
        exp_q.push_back(mk(1, 32'h200, 32'h12345677, 0, 0, 0));
        issue(1, 3'b000, 32'h200, 32'h77, 1, "cnt_sb");
        exp_q.push_back(mk(1, 32'h204, 32'hCAFEF00D, 0, 0, 0));
        issue(1, 3'b010, 32'h204, 32'hCAFEF00D, 0, "cnt_sw");
        exp_q.push_back(mk(0, 0, 0, 1, 32'h0, 1));
        issue(0, 3'b001, 32'h101, 0, 0, "cnt_lh_misaligned");
        @(negedge clk);
`ifdef MEM_ACCESS_CTRL_STATS_EN
        chk("load_cnt", load_cnt, 32'd1);
        chk("store_cnt", store_cnt, 32'd2);
        chk("stall_cnt", stall_cnt, 32'd2);
`else
        chk("load_cnt", load_cnt, 32'd0);
        chk("store_cnt", store_cnt, 32'd0);
        chk("stall_cnt", stall_cnt, 32'd0);
`endif
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
